mem_arbiter: RTL and testbench

Arbitrates the single-ported unified instruction/data memory of the multicycle RISC-V core between the core's memory port and a loader/debug port. It sequences each access over a fixed number of memory cycles, registers the read data, and returns a one-cycle ready pulse to the winning requester. The block sits between the controller/datapath memory interface (Adr, WriteData, MemWrite) and the memory macro.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Core/loader arbiter for the single-ported unified memory; MEM_ARB_RR_EN selects round-robin tie-break, else core has priority.
// Latency: ready pulses LAT+1 cycles after req is seen in IDLE; one transaction per LAT+2 cycles.
// Backpressure: requesters hold req and fields until their ready pulse; the losing port waits for the next IDLE.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ready,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_adr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ready,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          owner
);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_ready_d, l_ready_d;
    logic [DW-1:0] c_rdata_d, l_rdata_d;
    logic          m_en_d, m_we_d;
    logic [AW-1:0] m_adr_d;
    logic [DW-1:0] m_wdata_d;
    logic          owner_d;
    logic          grant_l;

`ifdef MEM_ARB_RR_EN
    // rr_last_q=1 means the loader won the previous grant; reset value lets the core win the first tie.
    logic rr_last_q;

    assign grant_l = l_req && (!c_req || !rr_last_q);

    always_ff @(posedge clk) begin
        if (reset)
            rr_last_q <= 1'b1;
        else if (state_q == IDLE && (c_req || l_req))
            rr_last_q <= grant_l;
    end
`else
    assign grant_l = l_req && !c_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        c_ready_d = 1'b0;
        l_ready_d = 1'b0;
        c_rdata_d = c_rdata;
        l_rdata_d = l_rdata;
        m_en_d    = m_en;
        m_we_d    = m_we;
        m_adr_d   = m_adr;
        m_wdata_d = m_wdata;
        owner_d   = owner;
        case (state_q)
            IDLE: begin
                if (c_req || l_req) begin
                    m_en_d    = 1'b1;
                    m_we_d    = grant_l ? l_we : c_we;
                    m_adr_d   = grant_l ? l_adr : c_adr;
                    m_wdata_d = grant_l ? l_wdata : c_wdata;
                    owner_d   = grant_l;
                    cnt_d     = CNT_INIT;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // m_rdata is only guaranteed in the final ACCESS cycle.
                    if (!m_we) begin
                        if (owner)
                            l_rdata_d = m_rdata;
                        else
                            c_rdata_d = m_rdata;
                    end
                    m_en_d    = 1'b0;
                    m_we_d    = 1'b0;
                    c_ready_d = !owner;
                    l_ready_d = owner;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_ready <= 1'b0;
            l_ready <= 1'b0;
            c_rdata <= '0;
            l_rdata <= '0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_adr   <= '0;
            m_wdata <= '0;
            owner   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_ready <= c_ready_d;
            l_ready <= l_ready_d;
            c_rdata <= c_rdata_d;
            l_rdata <= l_rdata_d;
            m_en    <= m_en_d;
            m_we    <= m_we_d;
            m_adr   <= m_adr_d;
            m_wdata <= m_wdata_d;
            owner   <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LAT=2 instance with a behavioural memory and per-port read-data scoreboards,
// plus a LAT=1 instance for the single-ACCESS-cycle case.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_adr, c_wdata, l_adr, l_wdata;
    logic        c_ready, l_ready, m_en, m_we, owner;
    logic [31:0] c_rdata, l_rdata, m_adr, m_wdata, m_rdata;

    logic        c1_req, c1_we;
    logic [31:0] c1_adr, c1_wdata;
    logic        l1_req = 1'b0, l1_we = 1'b0;
    logic [31:0] l1_adr = '0, l1_wdata = '0;
    logic        c1_ready, l1_ready, m1_en, m1_we, owner1;
    logic [31:0] c1_rdata, l1_rdata, m1_adr, m1_wdata, m1_rdata;

    logic [31:0] mem [0:63];
    assign m_rdata  = mem[m_adr[7:2]];
    assign m1_rdata = mem[m1_adr[7:2]];
    always @(posedge clk) if (m_en && m_we) mem[m_adr[7:2]] = m_wdata;

    mem_arbiter #(.AW(32), .DW(32), .LAT(2)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
        .l_ready(l_ready), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .owner(owner)
    );

    mem_arbiter #(.AW(32), .DW(32), .LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .c_req(c1_req), .c_we(c1_we), .c_adr(c1_adr), .c_wdata(c1_wdata),
        .c_ready(c1_ready), .c_rdata(c1_rdata),
        .l_req(l1_req), .l_we(l1_we), .l_adr(l1_adr), .l_wdata(l1_wdata),
        .l_ready(l1_ready), .l_rdata(l1_rdata),
        .m_en(m1_en), .m_we(m1_we), .m_adr(m1_adr), .m_wdata(m1_wdata),
        .m_rdata(m1_rdata), .owner(owner1)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] cq [$];
    logic [31:0] lq [$];
    logic [31:0] mon_exp;
    logic [31:0] l_last;

    // Scoreboard: every ready pulse must match the oldest outstanding expectation for that port.
    always @(negedge clk) begin
        if (c_ready) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL c_ready_unexpected got pulse want none");
            end else begin
                mon_exp = cq.pop_front();
                if (c_rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL c_rdata got %h want %h", c_rdata, mon_exp);
                end
            end
        end
        if (l_ready) begin
            checks++;
            if (lq.size() == 0) begin
                errors++;
                $display("FAIL l_ready_unexpected got pulse want none");
            end else begin
                mon_exp = lq.pop_front();
                if (l_rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL l_rdata got %h want %h", l_rdata, mon_exp);
                end
            end
        end
    end

    int          en_cnt, we_cnt, c_n, l_n;
    int          c_at [4];
    int          l_at [4];
    logic [31:0] en_adr, en_wdata;

    task automatic issue(input bit port, input bit we, input logic [31:0] adr, input logic [31:0] wd);
        if (port) begin
            l_req = 1'b1; l_we = we; l_adr = adr; l_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_adr = adr; c_wdata = wd;
        end
    endtask

    // Samples n+1 negedges (index 0 = request cycle); drops each req after its required pulse count.
    task automatic watch(input int n, input int c_need, input int l_need, input logic [31:0] c_adr_after);
        en_cnt = 0; we_cnt = 0; c_n = 0; l_n = 0;
        en_adr = '1; en_wdata = '1;
        for (int i = 0; i < 4; i++) begin c_at[i] = -1; l_at[i] = -1; end
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (m_en) begin
                en_cnt++;
                if (en_cnt == 1) begin en_adr = m_adr; en_wdata = m_wdata; end
            end
            if (m_we) we_cnt++;
            if (c_ready) begin
                if (c_n < 4) c_at[c_n] = k;
                c_n++;
                c_adr = c_adr_after;
                if (c_n >= c_need) c_req = 1'b0;
            end
            if (l_ready) begin
                if (l_n < 4) l_at[l_n] = k;
                l_n++;
                if (l_n >= l_need) l_req = 1'b0;
            end
        end
        c_req = 1'b0;
        l_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({c_ready, l_ready, m_en, m_we, owner} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {c_ready, l_ready, m_en, m_we, owner});
        end
        checks++;
        if (c_rdata !== 32'h0 || l_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0/0", c_rdata, l_rdata);
        end
        checks++;
        if (m_adr !== 32'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mbus got %h/%h want 0/0", m_adr, m_wdata);
        end
        checks++;
        if ({c1_ready, m1_en, owner1} !== 3'b0 || c1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_lat1 got %b/%h want 000/0", {c1_ready, m1_en, owner1}, c1_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_core_read();
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h10, 32'h0);
        cq.push_back(mem[4]);
        watch(8, 1, 0, 32'h10);
        checks++;
        if (c_n !== 1 || c_at[0] !== 3) begin
            errors++;
            $display("FAIL core_read_ready got n=%0d at=%0d want n=1 at=3", c_n, c_at[0]);
        end
        checks++;
        if (en_cnt !== 2 || en_adr !== 32'h10) begin
            errors++;
            $display("FAIL core_read_men got cycles=%0d adr=%h want 2/00000010", en_cnt, en_adr);
        end
        checks++;
        if (l_n !== 0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL core_read_loser got l_pulses=%0d owner=%b want 0/0", l_n, owner);
        end
    endtask

    task automatic test_loader_rw();
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h20, 32'h0);
        l_last = mem[8];
        lq.push_back(l_last);
        watch(8, 0, 1, 32'h0);
        checks++;
        if (l_n !== 1 || l_at[0] !== 3 || c_n !== 0) begin
            errors++;
            $display("FAIL loader_read got l=%0d at=%0d c=%0d want 1/3/0", l_n, l_at[0], c_n);
        end
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 32'h40, 32'h12345678);
        lq.push_back(l_last);
        watch(8, 0, 1, 32'h0);
        checks++;
        if (l_n !== 1 || l_at[0] !== 3) begin
            errors++;
            $display("FAIL loader_write_ready got n=%0d at=%0d want 1/3", l_n, l_at[0]);
        end
        checks++;
        if (we_cnt !== 2 || en_adr !== 32'h40 || en_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL loader_write_mbus got we=%0d adr=%h wd=%h want 2/00000040/12345678",
                     we_cnt, en_adr, en_wdata);
        end
        checks++;
        if (mem[16] !== 32'h12345678 || owner !== 1'b1) begin
            errors++;
            $display("FAIL loader_write_commit got mem=%h owner=%b want 12345678/1", mem[16], owner);
        end
    endtask

    task automatic test_arbitration();
        int exp_c1, exp_l0;
`ifdef MEM_ARB_RR_EN
        exp_c1 = 11; exp_l0 = 7;
`else
        exp_c1 = 7;  exp_l0 = 11;
`endif
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h8, 32'h0);
        issue(1'b1, 1'b0, 32'h24, 32'h0);
        cq.push_back(mem[2]);
        cq.push_back(mem[2]);
        lq.push_back(mem[9]);
        watch(16, 2, 1, 32'h8);
        checks++;
        if (c_n !== 2 || l_n !== 1) begin
            errors++;
            $display("FAIL arb_counts got c=%0d l=%0d want 2/1", c_n, l_n);
        end
        checks++;
        if (c_at[0] !== 3 || c_at[1] !== exp_c1 || l_at[0] !== exp_l0) begin
            errors++;
            $display("FAIL arb_order got c=%0d,%0d l=%0d want 3,%0d l=%0d",
                     c_at[0], c_at[1], l_at[0], exp_c1, exp_l0);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_access got m_en=%b want 1", m_en);
        end
        reset = 1'b1;
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_en, m_we, c_ready, owner} !== 4'b0 || c_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_state got %b rdata=%h want 0000/0", {m_en, m_we, c_ready, owner}, c_rdata);
        end
        reset = 1'b0;
        l_last = 32'h0;
        watch(5, 0, 0, 32'h0);
        checks++;
        if (c_n !== 0 || en_cnt !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet got pulses=%0d en=%0d want 0/0", c_n, en_cnt);
        end
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h14, 32'h0);
        issue(1'b1, 1'b0, 32'h28, 32'h0);
        cq.push_back(mem[5]);
        lq.push_back(mem[10]);
        watch(12, 1, 1, 32'h14);
        checks++;
        if (c_at[0] !== 3 || l_at[0] !== 7) begin
            errors++;
            $display("FAIL mid_reset_rerequest got c=%0d l=%0d want 3/7", c_at[0], l_at[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        cq.push_back(mem[0]);
        cq.push_back(mem[1]);
        watch(12, 2, 0, 32'h4);
        checks++;
        if (c_n !== 2 || c_at[0] !== 3 || c_at[1] - c_at[0] !== 4) begin
            errors++;
            $display("FAIL b2b_spacing got n=%0d at=%0d,%0d want 2 at 3,7", c_n, c_at[0], c_at[1]);
        end
        checks++;
        if (en_cnt !== 4) begin
            errors++;
            $display("FAIL b2b_men got %0d want 4", en_cnt);
        end
    endtask

    task automatic test_lat1();
        int n_en, rdy_at;
        logic [31:0] got;
        n_en = 0; rdy_at = -1; got = '1;
        @(posedge clk); #1;
        c1_req = 1'b1; c1_we = 1'b0; c1_adr = 32'h4; c1_wdata = 32'h0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (m1_en) n_en++;
            if (c1_ready) begin
                if (rdy_at < 0) rdy_at = k;
                got = c1_rdata;
                c1_req = 1'b0;
            end
        end
        c1_req = 1'b0;
        checks++;
        if (n_en !== 1 || rdy_at !== 2) begin
            errors++;
            $display("FAIL lat1_timing got en=%0d ready_at=%0d want 1/2", n_en, rdy_at);
        end
        checks++;
        if (got !== mem[1]) begin
            errors++;
            $display("FAIL lat1_rdata got %h want %h", got, mem[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 17);
        mem[4] = 32'hDEADBEEF;
        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_adr = '0; l_wdata = '0;
        c1_req = 1'b0; c1_we = 1'b0; c1_adr = '0; c1_wdata = '0;
        l_last = '0;

        test_reset();
        test_core_read();
        test_loader_rw();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        test_lat1();

        repeat (2) @(negedge clk);
        checks++;
        if (cq.size() != 0 || lq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got c=%0d l=%0d outstanding want 0/0", cq.size(), lq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
